// File: rtl/hamming_pkg.sv
// Shared Hamming(38,32) SEC definitions: sizes, parity layout and the
// syndrome / data-extraction helpers used by the encoder and decoder.
package hamming_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 38;
  localparam int PAR_W  = 6;

  // Code indices (position - 1) that carry parity bits, i.e. positions 2^k.
  localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15, 31};

  // True when code index idx holds a parity bit.
  function automatic logic is_parity_idx(input int idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < PAR_W; k++) begin
      if (PAR_IDX[k] == idx) begin
        r = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Each set code bit at position j contributes j to the XOR-sum syndrome.
  function automatic logic [PAR_W-1:0] syndrome_of(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int j = 1; j <= CODE_W; j++) begin
      s = s ^ ({PAR_W{code[j-1]}} & j[PAR_W-1:0]);
    end
    return s;
  endfunction

  // Data bits occupy the non-parity indices in ascending order; shifting each
  // one in from the top leaves the lowest index in data[0].
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (!is_parity_idx(i)) begin
        d = {code[i], d[DATA_W-1:1]};
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational 38 -> 6 syndrome generator, reusable by checkers.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [PAR_W-1:0]  syn_o
);

  assign syn_o = syndrome_of(code_i);

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(38,32) SEC decoder with valid/ready on both sides and
// saturating corrected/uncorrectable counters. Double errors whose syndrome
// falls in 1..38 are miscorrected silently; the code has no DED bit.
module hamming_decoder_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  if (NUM_STAGES != 2) begin : g_bad_num_stages
    $error("hamming_decoder_pipe: only NUM_STAGES=2 is supported");
  end

  localparam logic [CODE_W-1:0] CODE_ONE = {{(CODE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PAR_W-1:0]  SYN_MAX_POS = 6'd38;

  // Stage 1 state
  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;

  // Stage 2 (output) state
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [PAR_W-1:0]  out_syn_q;
  logic              out_corr_q;
  logic              out_uncorr_q;
  logic [CNT_W-1:0]  corr_cnt_q;
  logic [CNT_W-1:0]  uncorr_cnt_q;

  // Next-state / combinational
  logic [PAR_W-1:0]  in_syn_d;
  logic              s2_adv;
  logic              s1_adv;
  logic              out_hs;
  logic [CODE_W-1:0] fix_code_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_corr_d;
  logic              out_uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_d;

  hamming_syndrome u_syndrome (
    .code_i (in_code),
    .syn_o  (in_syn_d)
  );

  // Output stage drains when empty or consumed; input depends only on state.
  assign s2_adv = !out_valid_q || out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign out_hs = out_valid_q && out_ready;

  // Classify the stage-1 syndrome and flip the addressed bit when correctable.
  always_comb begin
    fix_code_d   = s1_code_q;
    out_corr_d   = 1'b0;
    out_uncorr_d = 1'b0;
    if (s1_syn_q == 6'd0) begin
      fix_code_d = s1_code_q;
    end else if (s1_syn_q <= SYN_MAX_POS) begin
      fix_code_d = s1_code_q ^ (CODE_ONE << (s1_syn_q - 6'd1));
      out_corr_d = 1'b1;
    end else begin
      out_uncorr_d = 1'b1;
    end
    out_data_d = extract_data(fix_code_d);
  end

  // Counter update: clear wins, otherwise count delivered words and saturate.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if (out_corr_q && (corr_cnt_q != CNT_MAX)) begin
        corr_cnt_d = corr_cnt_q + CNT_ONE;
      end else begin
        corr_cnt_d = corr_cnt_q;
      end
      if (out_uncorr_q && (uncorr_cnt_q != CNT_MAX)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
      end else begin
        uncorr_cnt_d = uncorr_cnt_q;
      end
    end else begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
    end
  end

  // Stage 1: capture the received codeword and its syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= in_syn_d;
      end
    end
  end

  // Stage 2: register corrected data and flags; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_syn_q    <= s1_syn_q;
        out_corr_q   <= out_corr_d;
        out_uncorr_q <= out_uncorr_d;
      end
    end
  end

  // Error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign in_ready      = s1_adv;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_syndrome  = out_syn_q;
  assign out_corrected = out_corr_q;
  assign out_uncorr    = out_uncorr_q;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Scoreboard bench for hamming_decoder_pipe (CNT_W=4 to reach saturation).
module tb_hamming_decoder_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  syn;
    logic        corr;
    logic        uncorr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [37:0] in_code = 38'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [5:0]  out_syndrome;
  logic        out_corrected;
  logic        out_uncorr;
  logic        cnt_clr = 1'b0;
  logic [3:0]  corr_cnt;
  logic [3:0]  uncorr_cnt;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] m_corr = 4'd0;
  logic [3:0] m_unc  = 4'd0;

  localparam logic [37:0] ONE38 = 38'h1;

  hamming_decoder_pipe #(.CNT_W(4), .NUM_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoder: data into non-power-of-two positions, then even parity.
  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [37:0] c;
    logic        b;
    int          n;
    c = 38'h0;
    n = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[n];
        n++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      b = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (p[k] && (p != (1 << k))) b = b ^ c[p-1];
      end
      c[(1 << k) - 1] = b;
    end
    return c;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [5:0] s,
                              input logic c, input logic u);
    exp_t e;
    e.data = d; e.syn = s; e.corr = c; e.uncorr = u;
    return e;
  endfunction

  // Output monitor: counter model and scoreboard comparison at each negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_corr = 4'd0;
        m_unc  = 4'd0;
      end else begin
        n_total++;
        if (corr_cnt !== m_corr) begin
          n_bad++; $display("FAIL corr_cnt: got %0d want %0d", corr_cnt, m_corr);
        end
        n_total++;
        if (uncorr_cnt !== m_unc) begin
          n_bad++; $display("FAIL uncorr_cnt: got %0d want %0d", uncorr_cnt, m_unc);
        end
        if (out_valid && out_ready) begin
          n_total++;
          if (sb.size() == 0) begin
            n_bad++; $display("FAIL unexpected_output: got data %h with empty queue", out_data);
            mon_e = mk(32'h0, 6'h0, 1'b0, 1'b0);
          end else begin
            mon_e = sb.pop_front();
            if ({out_data, out_syndrome, out_corrected, out_uncorr} !== mon_e) begin
              n_bad++;
              $display("FAIL decode: got data=%h syn=%0d c=%b u=%b want data=%h syn=%0d c=%b u=%b",
                       out_data, out_syndrome, out_corrected, out_uncorr,
                       mon_e.data, mon_e.syn, mon_e.corr, mon_e.uncorr);
            end
          end
        end else begin
          mon_e = mk(32'h0, 6'h0, 1'b0, 1'b0);
        end
        if (cnt_clr) begin
          m_corr = 4'd0;
          m_unc  = 4'd0;
        end else if (out_valid && out_ready) begin
          if (mon_e.corr && m_corr != 4'hF) m_corr = m_corr + 4'd1;
          if (mon_e.uncorr && m_unc != 4'hF) m_unc = m_unc + 4'd1;
        end
      end
    end
  end

  // Present one codeword (called at posedge+1), push expectation on accept.
  task automatic send(input logic [37:0] code, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (!in_ready) begin
      n_bad++; $display("FAIL send_timeout: in_ready got 0 want 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_total++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({out_valid, in_ready, out_data, out_syndrome, out_corrected, out_uncorr, corr_cnt, uncorr_cnt}
        !== {1'b0, 1'b1, 32'h0, 6'h0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b rdy=%b d=%h s=%0d cc=%0d uc=%0d want v=0 rdy=1 zeros",
               out_valid, in_ready, out_data, out_syndrome, corr_cnt, uncorr_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(38'h0, mk(32'h0, 6'd0, 1'b0, 1'b0));
    n_total++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL latency_early: out_valid got %b want 0", out_valid);
    end
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL latency: out_valid got %b want 1", out_valid);
    end
    wait_idle();
    n_total++;
    if (enc(32'h1) !== 38'h7) begin
      n_bad++; $display("FAIL ref_encoder: got %h want 7", enc(32'h1));
    end
    send(38'h7, mk(32'h1, 6'd0, 1'b0, 1'b0));
    send(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
    wait_idle();
    n_total++;
    if (corr_cnt !== 4'd1) begin
      n_bad++; $display("FAIL corr_cnt_one: got %0d want 1", corr_cnt);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [37:0] c;
    int          p;
    send(38'h1, mk(32'h0, 6'd1, 1'b1, 1'b0));
    send(38'h00_8000_0080, mk(32'h0, 6'd40, 1'b0, 1'b1));
    wait_idle();
    n_total++;
    if (uncorr_cnt !== 4'd1) begin
      n_bad++; $display("FAIL uncorr_cnt_one: got %0d want 1", uncorr_cnt);
    end
    for (int i = 0; i < 14; i++) begin
      d = $urandom;
      p = (i == 0) ? 38 : (i == 1) ? 1 : int'($urandom_range(38, 1));
      c = enc(d) ^ (ONE38 << (p - 1));
      send(c, mk(d, p[5:0], 1'b1, 1'b0));
    end
    d = $urandom;
    c = enc(d) ^ (ONE38 << 6) ^ (ONE38 << 31);
    send(c, mk(d ^ 32'h8, 6'd39, 1'b0, 1'b1));
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [37:0] codes [4];
    exp_t        exps  [4];
    logic [31:0] d;
    int          idx;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      codes[i] = enc(d) ^ (ONE38 << (i + 2));
      exps[i]  = mk(d, 6'(i + 3), 1'b1, 1'b0);
    end
    idx = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      in_code  = codes[idx];
      @(negedge clk);
      if (in_ready) sb.push_back(exps[idx]);
      if (out_valid) begin
        n_total++;
        if ({out_data, out_syndrome, out_corrected, out_uncorr} !== exps[0]) begin
          n_bad++; $display("FAIL stall_hold: got data=%h syn=%0d want data=%h syn=%0d",
                            out_data, out_syndrome, exps[0].data, exps[0].syn);
        end
      end
      @(posedge clk); #1;
      if (sb.size() > idx) idx++;
    end
    n_total++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_accept: got accepted=%0d in_ready=%b want 2 and 0", idx, in_ready);
    end
    out_ready = 1'b1;
    send(codes[2], exps[2]);
    send(codes[3], exps[3]);
    wait_idle();
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_total++;
    if (corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin
      n_bad++; $display("FAIL clear: got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
    end
    for (int i = 0; i < 17; i++) send(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
    wait_idle();
    n_total++;
    if (corr_cnt !== 4'hF) begin
      n_bad++; $display("FAIL saturate: got %h want f", corr_cnt);
    end
    out_ready = 1'b0;
    send(38'h3, mk(32'h1, 6'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL clr_setup: out_valid got %b want 1", out_valid);
    end
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_total++;
    if (corr_cnt !== 4'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_priority: got cnt=%0d v=%b want 0 and 0", corr_cnt, out_valid);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] d;
    out_ready = 1'b0;
    send(38'h7, mk(32'h1, 6'd0, 1'b0, 1'b0));
    send(38'h1, mk(32'h0, 6'd1, 1'b1, 1'b0));
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_setup: got v=%b rdy=%b want 1 and 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin
      n_bad++; $display("FAIL async_reset: got v=%b rdy=%b cc=%0d uc=%0d want 0 1 0 0",
                        out_valid, in_ready, corr_cnt, uncorr_cnt);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL stale_word: out_valid got %b want 0", out_valid);
      end
    end
    @(posedge clk); #1;
    d = $urandom;
    send(enc(d) ^ (ONE38 << 9), mk(d, 6'd10, 1'b1, 1'b0));
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_saturation();
    test_midreset();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
